// File: rtl/fpga_config_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpga_config_pkg
// Description : Shared types and constants for the FPGA configuration loader:
//               loader state encoding, default chain count, counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package fpga_config_pkg;

    // Default number of parallel configuration chains
    localparam int c_NUM_CHAINS_DEFAULT = 12;

    // Width of the per-load bit counter (CHAIN_LEN up to 65535)
    localparam int c_BIT_CNT_W = 16;

    // Width of the PRESET/SETTLE phase timer
    localparam int c_PHASE_CNT_W = 16;

    // Loader state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESET = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SETUP  = 3'd3,
        ST_PULSE  = 3'd4,
        ST_SETTLE = 3'd5,
        ST_DONE   = 3'd6
    } cfg_state_t;

    // A load is in progress in every state except IDLE and DONE
    function automatic logic is_busy_state(input cfg_state_t s);
        return !((s == ST_IDLE) || (s == ST_DONE));
    endfunction

endpackage : fpga_config_pkg
`default_nettype wire

// File: rtl/config_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module      : config_cycle_counter
// Description : Loadable down-counter with a zero flag. Times the fabric
//               preset phase and the post-shift settle phase.
// Revision    : 1.0 - initial release
// ============================================================================
module config_cycle_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load has priority over decrement; the count saturates at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_zero = (r_count == '0);

endmodule : config_cycle_counter
`default_nettype wire

// File: rtl/fpga_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : fpga_config_loader
// Description : Loads a bitstream into NUM_CHAINS parallel configuration
//               chains. Each bit takes LOAD -> SETUP -> PULSE (3 cycles min),
//               framed by a pReset phase and a settle phase before the
//               fabric I/Os are released from isolation.
// Revision    : 1.0 - initial release
// ============================================================================
module fpga_config_loader
    import fpga_config_pkg::*;
#(
    parameter int NUM_CHAINS    = c_NUM_CHAINS_DEFAULT,
    parameter int CHAIN_LEN     = 1024,
    parameter int PRESET_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_CHAINS-1:0] bs_data,
    input  logic                  bs_valid,
    output logic                  bs_ready,
    output logic [NUM_CHAINS-1:0] ccff_head,
    input  logic [NUM_CHAINS-1:0] ccff_tail,
    output logic                  prog_clk,
    output logic                  config_enable,
    output logic                  pReset,
    output logic                  IO_ISOL_N,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_CHAINS-1:0] tail_first
);

    // Timer reload values: the timer counts N-1 .. 0, giving N cycles
    localparam logic [c_PHASE_CNT_W-1:0] c_PRESET_LOAD = c_PHASE_CNT_W'(PRESET_CYCLES - 1);
    localparam logic [c_PHASE_CNT_W-1:0] c_SETTLE_LOAD = c_PHASE_CNT_W'(SETTLE_CYCLES - 1);
    // Bit counter value during the final PULSE of a load
    localparam logic [c_BIT_CNT_W-1:0]   c_LAST_BIT    = c_BIT_CNT_W'(CHAIN_LEN - 1);

    cfg_state_t                r_state;
    cfg_state_t                w_next_state;
    logic [c_BIT_CNT_W-1:0]    r_bit_cnt;
    logic [NUM_CHAINS-1:0]     r_ccff_head;
    logic [NUM_CHAINS-1:0]     r_tail_first;
    logic                      r_prog_clk;
    logic                      r_config_enable;
    logic                      r_preset;
    logic                      r_io_isol_n;
    logic                      r_bs_ready;
    logic                      r_busy;
    logic                      r_done;

    logic                      w_accept_start;
    logic                      w_handshake;
    logic                      w_first_pulse;
    logic                      w_tmr_load;
    logic [c_PHASE_CNT_W-1:0]  w_tmr_value;
    logic                      w_tmr_dec;
    logic                      w_tmr_zero;

    // start only counts from IDLE or DONE; while busy it is ignored
    assign w_accept_start = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
    assign w_handshake    = (r_state == ST_LOAD) && bs_valid;
    assign w_first_pulse  = (r_state == ST_PULSE) && (r_bit_cnt == '0);

    config_cycle_counter #(
        .WIDTH (c_PHASE_CNT_W)
    ) u_phase_timer (
        .clk          (clk),
        .rst          (reset),
        .i_load       (w_tmr_load),
        .i_load_value (w_tmr_value),
        .i_dec        (w_tmr_dec),
        .o_zero       (w_tmr_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and phase-timer control
    always_comb begin
        w_next_state = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_value  = '0;
        w_tmr_dec    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next_state = ST_PRESET;
                    w_tmr_load   = 1'b1;
                    w_tmr_value  = c_PRESET_LOAD;
                end
            end
            ST_PRESET: begin
                if (w_tmr_zero) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_LOAD: begin
                if (bs_valid) begin
                    w_next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_next_state = ST_PULSE;
            end
            ST_PULSE: begin
                if (r_bit_cnt == c_LAST_BIT) begin
                    w_next_state = ST_SETTLE;
                    w_tmr_load   = 1'b1;
                    w_tmr_value  = c_SETTLE_LOAD;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_SETTLE: begin
                if (w_tmr_zero) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Control outputs are registered from the next state so they line up
    // with the state they describe and are glitch-free toward the fabric
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prog_clk      <= 1'b0;
            r_config_enable <= 1'b0;
            r_preset        <= 1'b0;
            r_bs_ready      <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_io_isol_n     <= 1'b0;
        end else begin
            r_prog_clk      <= (w_next_state == ST_PULSE);
            r_config_enable <= is_busy_state(w_next_state);
            r_preset        <= (w_next_state == ST_PRESET);
            r_bs_ready      <= (w_next_state == ST_LOAD);
            r_busy          <= is_busy_state(w_next_state);
            r_done          <= (w_next_state == ST_DONE);
            r_io_isol_n     <= (w_next_state == ST_DONE);
        end
    end

    // Bit counter, chain-head data and first-pulse tail capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt    <= '0;
            r_ccff_head  <= '0;
            r_tail_first <= '0;
        end else begin
            if (w_accept_start) begin
                r_bit_cnt <= '0;
            end else if (r_state == ST_PULSE) begin
                r_bit_cnt <= r_bit_cnt + {{(c_BIT_CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_handshake) begin
                r_ccff_head <= bs_data;
            end
            if (w_first_pulse) begin
                r_tail_first <= ccff_tail;
            end
        end
    end

    assign bs_ready      = r_bs_ready;
    assign ccff_head     = r_ccff_head;
    assign prog_clk      = r_prog_clk;
    assign config_enable = r_config_enable;
    assign pReset        = r_preset;
    assign IO_ISOL_N     = r_io_isol_n;
    assign busy          = r_busy;
    assign done          = r_done;
    assign tail_first    = r_tail_first;

endmodule : fpga_config_loader
`default_nettype wire
